// File: rtl/pixel_window_gen.sv
// -----------------------------------------------------------------------------
// pixel_window_gen
//
// Purpose:
//   Turns a raster stream of 8-bit luma samples into a sliding 8-tap window
//   for a downstream horizontal filter. Each row first fills the 8-deep
//   shift register. After that, every accepted pixel produces one window, so
//   a row of ROW_WIDTH pixels gives ROW_WIDTH-7 windows. A window never
//   contains pixels from two different rows. The fractional-position code
//   sampled with a row's first pixel travels with every window of that row.
//
// Parameters:
//   ROW_WIDTH   pixels per row (8..1023)
//
// Ports:
//   clock        single clock, rising edge
//   reset        asynchronous, active-high
//   pix_in       [7:0]  unsigned luma sample, left-to-right raster order
//   pix_valid    pix_in holds a valid sample
//   pix_ready    block accepts pix_in this cycle
//   frac_in      [1:0]  row fractional code, sampled with the row's first pixel
//   inputPixels  [63:0] window; [7:0] oldest (leftmost), [63:56] newest
//   s            [1:0]  frac code of the row that produced the window
//   win_valid    inputPixels / s / row_last are valid
//   win_ready    downstream consumes the window this cycle
//   row_last     current window is the final window of its row
// -----------------------------------------------------------------------------
module pixel_window_gen #(
  parameter int ROW_WIDTH = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  pix_in,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [1:0]  frac_in,
  output logic [63:0] inputPixels,
  output logic [1:0]  s,
  output logic        win_valid,
  input  logic        win_ready,
  output logic        row_last
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FILL   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  localparam logic [9:0] LP_ROW_LEN = 10'(ROW_WIDTH);
  localparam logic [9:0] LP_TAPS    = 10'd8;

  logic [1:0]  r_state;
  logic [9:0]  r_col;
  logic [63:0] r_shift;
  logic [1:0]  r_frac;
  logic [63:0] r_window;
  logic [1:0]  r_s;
  logic        r_win_valid;
  logic        r_row_last;

  logic        w_pix_ready;
  logic        w_accept;
  logic        w_produce;
  logic        w_row_end;
  logic [9:0]  w_col_next;
  logic [1:0]  w_state_next;
  logic [63:0] w_shift_next;

  // The window register is the only storage, so an upstream pixel can be
  // taken only if that slot is empty or is being drained this same cycle.
  assign w_pix_ready = !r_win_valid || win_ready;
  assign w_accept    = pix_valid && w_pix_ready;

  // Newest pixel enters at the top byte; the oldest drops out of [7:0].
  assign w_shift_next = {pix_in, r_shift[63:8]};

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_col_next   = (r_state == ST_IDLE) ? 10'd1 : r_col + 10'd1;
    w_row_end    = (w_col_next == LP_ROW_LEN);
    w_produce    = 1'b0;
    w_state_next = r_state;

    case (r_state)
      ST_IDLE: begin
        // A row is at least 8 pixels, so its first pixel can never end it.
        if (w_accept) w_state_next = ST_FILL;
      end
      ST_FILL: begin
        if (w_accept && (w_col_next == LP_TAPS)) begin
          w_produce = 1'b1;
          // An 8-pixel row is complete once its single window is made.
          w_state_next = w_row_end ? ST_IDLE : ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (w_accept) begin
          w_produce = 1'b1;
          if (w_row_end) w_state_next = ST_IDLE;
        end
      end
      default: begin
        // Unused encoding: fall back to IDLE. The column count is cleared
        // through the normal accept path, or on the next reset.
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // NOTE: state updates use non-blocking assignments, so every register
  // samples the values from before the edge, whatever the statement order.
  // NOTE: the shift register is plain flops rather than a RAM, so it is
  // cleared with the rest of the state. A reset in mid-row therefore leaves
  // no stale pixels that a later window could pick up.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_col   <= 10'd0;
      r_shift <= 64'h0;
      r_frac  <= 2'b00;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_shift <= w_shift_next;
        // The column count returns to 0 whenever the row finishes.
        r_col   <= (w_state_next == ST_IDLE) ? 10'd0 : w_col_next;
        if (r_state == ST_IDLE) r_frac <= frac_in;
      end
    end
  end

  // Output window register. A production overrides a concurrent consume,
  // so back-to-back windows stream with no bubble.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_window    <= 64'h0;
      r_s         <= 2'b00;
      r_win_valid <= 1'b0;
      r_row_last  <= 1'b0;
    end else if (w_produce) begin
      r_window    <= w_shift_next;
      r_s         <= r_frac;
      r_win_valid <= 1'b1;
      r_row_last  <= w_row_end;
    end else if (r_win_valid && win_ready) begin
      r_win_valid <= 1'b0;
      r_row_last  <= 1'b0;
    end
  end

  assign pix_ready   = w_pix_ready;
  assign inputPixels = r_window;
  assign s           = r_s;
  assign win_valid   = r_win_valid;
  assign row_last    = r_row_last;

endmodule

// File: tb/tb_pixel_window_gen.sv
// -----------------------------------------------------------------------------
// tb_pixel_window_gen
//
// Directed bench for pixel_window_gen. A 16-pixel-row instance carries most
// of the scenarios. An 8-pixel-row instance covers the degenerate
// single-window row. Windows are captured on the falling edge whenever a
// consume is about to happen, then compared with hand-computed values.
// -----------------------------------------------------------------------------
module tb_pixel_window_gen;

  typedef struct packed {
    logic [63:0] d;
    logic [1:0]  s;
    logic        last;
  } win_t;

  logic        clock;
  logic        reset;
  logic [7:0]  pix_in;
  logic [1:0]  frac_in;
  logic        pix_valid;
  logic        win_ready;
  logic        sel8;

  logic        pv16, pr16, wv16, last16;
  logic [63:0] win16;
  logic [1:0]  s16;
  logic        pv8, pr8, wv8, last8;
  logic [63:0] win8;
  logic [1:0]  s8;

  int vectors = 0;
  int errors  = 0;
  win_t cap16[$];
  win_t cap8[$];

  assign pv16 = pix_valid & ~sel8;
  assign pv8  = pix_valid & sel8;

  pixel_window_gen #(.ROW_WIDTH(16)) dut16 (
    .clock(clock), .reset(reset), .pix_in(pix_in), .pix_valid(pv16),
    .pix_ready(pr16), .frac_in(frac_in), .inputPixels(win16), .s(s16),
    .win_valid(wv16), .win_ready(win_ready), .row_last(last16)
  );

  pixel_window_gen #(.ROW_WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .pix_in(pix_in), .pix_valid(pv8),
    .pix_ready(pr8), .frac_in(frac_in), .inputPixels(win8), .s(s8),
    .win_valid(wv8), .win_ready(win_ready), .row_last(last8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // A window is consumed at the next rising edge exactly when this holds.
  always @(negedge clock) begin
    if (wv16 && win_ready) cap16.push_back('{d: win16, s: s16, last: last16});
    if (wv8 && win_ready)  cap8.push_back('{d: win8, s: s8, last: last8});
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Window k of a row whose pixels are base, base+1, ...
  function automatic logic [63:0] exp_win(input logic [7:0] base, input int k);
    logic [63:0] w;
    for (int j = 0; j < 8; j++) w[j*8 +: 8] = base + 8'(k + j);
    return w;
  endfunction

  // Present one pixel and hold it until it has been accepted.
  task automatic push(input logic [7:0] d, input logic [1:0] f);
    int n;
    n = 0;
    pix_in    = d;
    frac_in   = f;
    pix_valid = 1'b1;
    @(negedge clock);
    while (!(sel8 ? pr8 : pr16) && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) check("push_timeout", 64'(sel8 ? pr8 : pr16), 64'd1);
    @(posedge clock);
    #1;
    pix_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (3) @(posedge clock);
    #1;
  endtask

  // Check the 9 windows of one 16-pixel row starting at cap16[first].
  task automatic check_row(input string tag, input int first,
                           input logic [7:0] base, input logic [1:0] f);
    for (int k = 0; k < 9; k++) begin
      if (first + k < cap16.size()) begin
        check({tag, "_data"}, cap16[first+k].d, exp_win(base, k));
        check({tag, "_s"}, 64'(cap16[first+k].s), 64'(f));
        check({tag, "_last"}, 64'(cap16[first+k].last), (k == 8) ? 64'd1 : 64'd0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    pix_in    = 8'h00;
    frac_in   = 2'b00;
    pix_valid = 1'b0;
    win_ready = 1'b0;
    sel8      = 1'b0;

    // Reset state
    #3;
    check("rst_valid", 64'(wv16), 64'd0);
    check("rst_win", win16, 64'h0);
    check("rst_s", 64'(s16), 64'd0);
    check("rst_last", 64'(last16), 64'd0);
    check("rst_ready", 64'(pr16), 64'd1);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rel_ready", 64'(pr16), 64'd1);

    // Continuous row 0x01..0x10, frac 2
    win_ready = 1'b1;
    cap16.delete();
    for (int i = 0; i < 16; i++) begin
      push(8'(i + 1), 2'd2);
      if (i < 7) check("fill_no_win", 64'(wv16), 64'd0);
      if (i == 7) begin
        check("first_lat_valid", 64'(wv16), 64'd1);
        check("first_win", win16, 64'h0807060504030201);
      end
    end
    drain();
    check("r1_count", 64'(cap16.size()), 64'd9);
    if (cap16.size() == 9) begin
      check("r1_last_win", cap16[8].d, 64'h100F0E0D0C0B0A09);
      check("r1_last_flag", 64'(cap16[8].last), 64'd1);
    end
    check_row("r1", 0, 8'h01, 2'd2);
    check("consume_clr_valid", 64'(wv16), 64'd0);
    check("consume_clr_last", 64'(last16), 64'd0);

    // Back-pressure after the first window
    cap16.delete();
    win_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'h20 + 8'(i), 2'd0);
    pix_in    = 8'h28;
    pix_valid = 1'b1;
    repeat (5) begin
      @(negedge clock);
      check("stall_ready", 64'(pr16), 64'd0);
      check("stall_valid", 64'(wv16), 64'd1);
      check("stall_hold", win16, exp_win(8'h20, 0));
    end
    @(posedge clock);
    #1;
    win_ready = 1'b1;
    for (int i = 8; i < 16; i++) push(8'h20 + 8'(i), 2'd0);
    drain();
    check("r2_count", 64'(cap16.size()), 64'd9);
    check_row("r2", 0, 8'h20, 2'd0);

    // Two back-to-back rows; frac_in varies after each row's first pixel
    cap16.delete();
    for (int i = 0; i < 16; i++) push(8'h40 + 8'(i), (i == 0) ? 2'd1 : 2'(i));
    for (int i = 0; i < 16; i++) push(8'h80 + 8'(i), (i == 0) ? 2'd3 : 2'd0);
    drain();
    check("r3_count", 64'(cap16.size()), 64'd18);
    check_row("r3a", 0, 8'h40, 2'd1);
    check_row("r3b", 9, 8'h80, 2'd3);

    // Gapped input: one idle cycle after every pixel
    cap16.delete();
    for (int i = 0; i < 16; i++) begin
      push(8'h50 + 8'(i), 2'd1);
      @(posedge clock);
      #1;
    end
    drain();
    check("r4_count", 64'(cap16.size()), 64'd9);
    check_row("r4", 0, 8'h50, 2'd1);

    // Reset with a held window pending
    for (int i = 0; i < 10; i++) push(8'h60 + 8'(i), 2'd3);
    win_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", 64'(wv16), 64'd0);
    check("arst_win", win16, 64'h0);
    check("arst_s", 64'(s16), 64'd0);
    check("arst_last", 64'(last16), 64'd0);
    check("arst_ready", 64'(pr16), 64'd1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    win_ready = 1'b1;
    check("arst_rel_ready", 64'(pr16), 64'd1);

    // Reset after 5 pixels of a row, then a fresh row
    for (int i = 0; i < 5; i++) push(8'h90 + 8'(i), 2'd2);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 64'(wv16), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    cap16.delete();
    for (int i = 0; i < 16; i++) begin
      push(8'hA0 + 8'(i), 2'd1);
      if (i == 6) check("refill_no_win", 64'(wv16), 64'd0);
    end
    drain();
    check("r5_count", 64'(cap16.size()), 64'd9);
    check_row("r5", 0, 8'hA0, 2'd1);

    // ROW_WIDTH = 8: one window per row
    sel8 = 1'b1;
    cap8.delete();
    for (int i = 0; i < 8; i++) push(8'hFF, 2'd2);
    drain();
    check("w8_count", 64'(cap8.size()), 64'd1);
    if (cap8.size() == 1) begin
      check("w8_data", cap8[0].d, 64'hFFFFFFFFFFFFFFFF);
      check("w8_last", 64'(cap8[0].last), 64'd1);
      check("w8_s", 64'(cap8[0].s), 64'd2);
    end
    sel8 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/pixel_window_gen.md
PIXEL_WINDOW_GEN -- requirements
Module: pixel_window_gen

Interface
REQ-001 The block SHALL have parameter ROW_WIDTH, default 64, meaning pixels per row (legal range 8..1023).
REQ-002 The block SHALL have port clock, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, meaning reset that is asynchronous and active-high.
REQ-004 The block SHALL have port pix_in, input, 8, meaning the unsigned luma sample, left-to-right raster order.
REQ-005 The block SHALL have port pix_valid, input, 1, meaning pix_in holds a valid sample.
REQ-006 The block SHALL have port pix_ready, output, 1, meaning the block accepts pix_in this cycle.
REQ-007 The block SHALL have port frac_in, input, 2, meaning the fractional-position code for the row, sampled with the row's first pixel.
REQ-008 The block SHALL have port inputPixels, output, 64, meaning an 8-tap window; [7:0] is the oldest (leftmost) pixel and [63:56] the newest.
REQ-009 The block SHALL have port s, output, 2, meaning the frac code of the row that produced the current window.
REQ-010 The block SHALL have port win_valid, output, 1, meaning inputPixels, s and row_last are valid.
REQ-011 The block SHALL have port win_ready, input, 1, meaning the downstream filter consumes the window this cycle.
REQ-012 The block SHALL have port row_last, output, 1, meaning the current window is the final window of its row.

Function
REQ-013 A pixel SHALL be accepted exactly on cycles with pix_valid=1 and pix_ready=1; a window SHALL be consumed exactly on cycles with win_valid=1 and win_ready=1.
REQ-014 pix_ready SHALL equal (!win_valid | win_ready), combinationally, with no internal skid storage.
REQ-015 The block SHALL implement a state machine IDLE -> FILL -> STREAM -> IDLE, encoded in a 2-bit register.
REQ-016 IDLE: on an accepted pixel, the block SHALL latch frac_in into the row-frac register, set the column count to 1, shift the pixel in, and go to FILL.
REQ-017 FILL: each accepted pixel SHALL shift in and increment the column count; the accept that makes the count 8 SHALL produce a window and go to STREAM.
REQ-018 STREAM: each accepted pixel SHALL shift in, increment the column count and produce a window; the accept that makes the count ROW_WIDTH SHALL also set row_last and go to IDLE.
REQ-019 Producing a window SHALL register the eight newest pixels (including the one just accepted) into inputPixels, the row frac into s, and assert win_valid on the next cycle (latency 1 cycle).
REQ-020 Each row SHALL produce exactly ROW_WIDTH-7 windows, and row_last SHALL be 1 only on the last of them.
REQ-021 When win_valid=1 and win_ready=0, inputPixels, s, row_last and win_valid SHALL hold, and no pixel SHALL be accepted.
REQ-022 A consume with no simultaneous window production SHALL clear win_valid and row_last next cycle.
REQ-023 A consume and a new production in the same cycle SHALL keep win_valid=1 and load the new window with no bubble.
REQ-024 Pixels accepted in FILL SHALL never assert win_valid.
REQ-025 The shift register SHALL be 8x8 bits; the column counter SHALL be 10 bits and return to 0 in IDLE; windows SHALL never span two rows.
REQ-026 frac_in SHALL be ignored except on the first accepted pixel of a row.
REQ-027 When ROW_WIDTH=8, FILL->STREAM SHALL be skipped and the 8th pixel SHALL produce one window with row_last=1, returning to IDLE.

Reset
REQ-028 While reset=1, regardless of clock: state=IDLE, column count=0, shift register=0, inputPixels=64'h0, s=2'b00, win_valid=0, row_last=0.
REQ-029 pix_ready SHALL be 1 during reset and on the first cycle after release; an asserted reset in mid-row SHALL discard the partial row and any unconsumed window.

Verification
REQ-030 Scenario: ROW_WIDTH=16, pixels 0x01..0x10 continuous, win_ready=1, frac_in=2 -> 9 windows; first 64'h0807060504030201 one cycle after the 8th accept; last 64'h100F0E0D0C0B0A09 with row_last=1; s=2 throughout.
REQ-031 Scenario: hold win_ready=0 after the first window -> pix_ready=0, window is stable for 5 cycles; on release, windows resume with no loss or duplication.
REQ-032 Scenario: two back-to-back rows with frac_in=1 then 3 -> row 2's first window appears after 8 of its own pixels, never mixes row 1 pixels, and has s=3.
REQ-033 Scenario: pix_valid toggling 1,0,1,0 -> window contents identical to a continuous input, and one window per accepted pixel in STREAM.
REQ-034 Scenario: assert reset after 5 pixels of a row -> all outputs zero immediately; the next row restarts from IDLE with a full 8-pixel fill.
REQ-035 Scenario: ROW_WIDTH=8, pixels 0xFF x8 -> exactly one window 64'hFFFFFFFFFFFFFFFF with row_last=1.
